// File: rtl/cls_sub_serial_pkg.sv
// Shared constants, state encoding and sizing helpers for the serial
// slice-at-a-time subtractor.
package cls_sub_serial_pkg;

    localparam int SLICE_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Keeps the slice index at least one bit wide when there is a single slice.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cls_sub_serial_if.sv
// Operand/result bundle for cls_sub_serial; the sequencer side is the master.
interface cls_sub_serial_if #(parameter int WIDTH = 32) ();

    // Handshake: start is taken on any rising edge where busy=0 (idle or the
    // done cycle); done pulses for one cycle with diff and the flags valid,
    // and they hold until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, zero, negative, overflow
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, zero, negative, overflow
    );

endinterface

// File: rtl/cls_sub_serial_sub_slice.sv
// Combinational SLICE-bit subtractor with borrow chaining, the mirror of the
// adder slice unit.
module cls_sub_serial_sub_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             borrow_in,
    output logic [SLICE-1:0] d,
    output logic             borrow_out
);

    // The extra top bit of the widened difference is set exactly when the
    // slice result went negative, which is the outgoing borrow.
    assign {borrow_out, d} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, borrow_in};

endmodule

// File: rtl/cls_sub_serial.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, one slice per clock,
// LSB slice first, with a single shared slice unit.
module cls_sub_serial
    import cls_sub_serial_pkg::*;
#(
    parameter int WIDTH = 32,  // must be a multiple of SLICE
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    cls_sub_serial_if.slave   bus,
    output state_t            state_dbg
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_next;
    logic             borrow_r;
    logic [IDXW-1:0]  idx;
    logic             busy_r;
    logic             done_r;
    logic             borrow_out_r;
    logic             zero_r;
    logic             negative_r;
    logic             overflow_r;

    logic [SLICE-1:0] a_k;
    logic [SLICE-1:0] b_k;
    logic [SLICE-1:0] d_k;
    logic             bo_k;

    assign a_k = a_r[int'(idx) * SLICE +: SLICE];
    assign b_k = b_r[int'(idx) * SLICE +: SLICE];

    cls_sub_serial_sub_slice #(.SLICE(SLICE)) u_slice (
        .a          (a_k),
        .b          (b_k),
        .borrow_in  (borrow_r),
        .d          (d_k),
        .borrow_out (bo_k)
    );

    // Full result as it will stand after this edge; the flags are taken from it
    // on the last slice so they see the complete difference.
    always_comb begin
        diff_next = diff_r;
        diff_next[int'(idx) * SLICE +: SLICE] = d_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            diff_r       <= '0;
            borrow_r     <= 1'b0;
            idx          <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            borrow_out_r <= 1'b0;
            zero_r       <= 1'b0;
            negative_r   <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        borrow_r <= bus.borrow_in;
                        idx      <= '0;
                        diff_r   <= '0;
                        busy_r   <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    diff_r   <= diff_next;
                    borrow_r <= bo_k;
                    idx      <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state        <= DONE;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        borrow_out_r <= bo_k;
                        zero_r       <= (diff_next == '0);
                        negative_r   <= diff_next[WIDTH-1];
                        overflow_r   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                        (diff_next[WIDTH-1] != a_r[WIDTH-1]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;
    assign bus.zero       = zero_r;
    assign bus.negative   = negative_r;
    assign bus.overflow   = overflow_r;
    assign state_dbg      = state;

endmodule

// File: tb/tb_cls_sub_serial.sv
// Bench for cls_sub_serial: directed and random operations, results checked
// against an integer-arithmetic reference model through an expected queue.
module tb_cls_sub_serial;
  import cls_sub_serial_pkg::*;

  localparam int W  = 32;
  localparam int SL = 8;
  localparam int NS = W / SL;
  localparam int EW = W + 4;

  // clock / reset
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  int     cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cls_sub_serial_if #(.WIDTH(W)) bus ();

  cls_sub_serial #(.WIDTH(W), .SLICE(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [EW-1:0] last_exp = '0;
  int            n_vec = 0;
  int            n_err = 0;

  // Reference: {borrow_out, zero, negative, overflow, diff} from wide integer math.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bin);
    longint   ud, sd;
    logic [W-1:0] d;
    logic     bo, ovf;
    ud  = longint'(a) - longint'(b) - longint'(bin);
    sd  = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    d   = W'(ud);
    bo  = (ud < 0);
    ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {bo, (d == '0), d[W-1], ovf, d};
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return {bus.borrow_out, bus.zero, bus.negative, bus.overflow, bus.diff};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %0s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            c;
    if (!rst_n) begin
      last_exp = '0;
      check("reset_outputs", {26'd0, bus.busy, bus.done, dut_vec()}, 64'd0);
      check("reset_state", 64'(state_dbg), 64'(IDLE));
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_done at cycle %0d: got=done expected=no done", cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("result", 64'(dut_vec()), 64'(e));
        check("latency", 64'(cyc), 64'(c));
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("state_at_done", 64'(state_dbg), 64'(DONE));
        last_exp = e;
      end
    end else if (bus.busy) begin
      check("flags_hold_busy", 64'(dut_vec() >> W), 64'(last_exp >> W));
    end else begin
      check("idle_hold", 64'(dut_vec()), 64'(last_exp));
    end
  end

  // driver tasks: called at a negedge while the DUT is known to be able to accept
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.a         = a;
    bus.b         = b;
    bus.borrow_in = bin;
    bus.start     = 1'b1;
    exp_q.push_back(model(a, b, bin));
    exp_cyc_q.push_back(cyc + 1 + NS);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    drive_op(a, b, bin);
    repeat (NS) @(negedge clk);
  endtask

  initial begin
    int gap;
    int g;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic, borrow across slice boundary, full-width borrow
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0); @(negedge clk);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0); @(negedge clk);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0); @(negedge clk);
    // signed overflow, zero result
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0); @(negedge clk);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0); @(negedge clk);

    // borrow_in, operand change and start pulse while busy, then back-to-back
    drive_op(32'd10, 32'd3, 1'b1);
    @(negedge clk);
    bus.a     = '1;
    bus.b     = '1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (NS - 2) @(negedge clk);
    run_op(32'd7, 32'd7, 1'b0);
    @(negedge clk);

    // reset in the middle of an operation
    drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {26'd0, bus.busy, bus.done, dut_vec()}, 64'd0);
    check("abort_state", 64'(state_dbg), 64'(IDLE));
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd9, 32'd4, 1'b0);
    @(negedge clk);

    // random operations with random gaps and ignored start pulses
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: rb = ra + 32'd1;
        2: ra = $urandom_range(0, 255);
        default: ;
      endcase
      drive_op(ra, rb, 1'($urandom_range(0, 1)));
      g = $urandom_range(0, 2 * NS);
      for (int j = 0; j < NS; j++) begin
        if (j == g) begin
          bus.a     = $urandom;
          bus.b     = $urandom;
          bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    repeat (NS + 3) @(negedge clk);
    check("all_results_seen", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cls_sub_serial.md
Name: cls_sub_serial

Overview:
- Multi-cycle subtractor: the inverse-direction counterpart to the team's sliced carry-chain adders.
- Computes diff = a - b - borrow_in over WIDTH bits, one SLICE-bit slice per clock, LSB slice first.
- A borrow register carries the chain between slices, so only one slice's worth of arithmetic logic is instantiated.
- Sits beside the cls adders in the arithmetic library. Driven by a start/busy/done handshake from a sequencer or testbench.

Parameters:
- WIDTH, 32, operand and result width in bits; must be an integer multiple of SLICE.
- SLICE, 8, bits processed per cycle.
- NSLICE (derived, localparam), WIDTH/SLICE, number of compute cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- borrow_in  input  1  initial borrow; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  result; held stable until the next accepted start.
- borrow_out  output  1  final borrow; 1 means a < b + borrow_in (unsigned).
- zero  output  1  diff == 0.
- negative  output  1  diff[WIDTH-1].
- overflow  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (async assert, synchronous-safe deassert): state=IDLE; busy, done, diff, borrow_out, zero, negative, overflow all 0; internal operand, borrow and slice-index registers 0.
- States:
  - IDLE: busy=0. start=1 at edge T0 latches a, b, borrow_in, clears slice index and diff, sets busy=1, goes to RUN.
  - RUN: at each edge T1..T(NSLICE), slice k = index is computed:
    - {bo, d} = a_k - b_k - borrow_reg, SLICE-bit wrap-around.
    - d is written into diff[k*SLICE +: SLICE]; borrow_reg <= bo; index increments.
    - At edge T(NSLICE) (last slice) the block goes to DONE. On that same edge: busy <= 0, done <= 1, and borrow_out, zero, negative and overflow are registered from the final values.
  - DONE: lasts one cycle (done=1, busy=0), then returns to IDLE.
  - Default latency is 4 cycles from the accepting edge to done=1.
- Flags are computed on the full result. zero, negative and overflow update only at completion; mid-operation, flag outputs keep their previous values.
- diff is partially updated during RUN. Consumers use it only when done=1 or while idle after done.
- start while busy=1 is ignored: no re-capture and no effect on the running operation.
- start during the DONE cycle (busy=0) is accepted. This gives back-to-back operation, throughput of one result per NSLICE+1 cycles.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0. No done is produced.
- Operands are captured, so a and b may change after the accepting edge without affecting the result.

Decomposition:
- Shared arithmetic package:
  - SLICE default.
  - Localparam helper for NSLICE.
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One natural sub-module: sub_slice, a combinational SLICE-bit subtractor with borrow_in/borrow_out. It mirrors the adder slice unit and is instantiated once, fed by index-muxed operand slices.

Test Plan:
- a=0x00000005, b=0x00000003, borrow_in=0, start at T0 -> done at T4: diff=0x00000002, borrow_out=0, zero=0, negative=0, overflow=0.
- a=0x00000100, b=0x00000001 -> diff=0x000000FF, borrow_out=0 (borrow ripples across the slice 0/1 boundary). Then a=0, b=1 -> diff=0xFFFFFFFF, borrow_out=1, negative=1.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, overflow=1, negative=0. Then a=0x12345678, b=0x12345678 -> diff=0, zero=1.
- a=10, b=3, borrow_in=1 -> diff=0x00000006. Change a and b to 0xFFFFFFFF and pulse start at T2 (while busy) -> result unchanged, one done pulse only.
- Assert start again in the DONE cycle with a=7, b=7 -> accepted, second done 5 cycles after the first, zero=1.
- Start a=0xFFFFFFFF, b=1 and drop rst_n at T2 -> busy=0, done=0, diff=0 immediately. After release, start a=9, b=4 -> diff=5 at T4, no stray done from the aborted operation.
